// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one combinational ALU that sits outside this
// block. A winner is picked in IDLE. Its operands and control code are
// registered and drive the ALU for one EXEC cycle. The ALU result is then
// captured and held on a tagged valid/ready response channel until the
// consumer takes it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_* / req1_*           requester channels: valid/ready handshake plus
//                             operands a, b and ALU control code
//   alu_a, alu_b, alu_ctrl    registered operands into the external ALU
//   alu_result                combinational result back from the ALU
//   rsp_valid/ready/id/data   tagged response channel (id = requester 0/1)
//   busy                      high while an operation is in flight
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int CTRL_W      = 4,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic              last_grant;
  logic              op_id;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [CTRL_W-1:0] op_ctrl;

  logic              grant_any;
  logic              grant_id;
  logic              accept;

  // Arbitration. Under contention, round-robin hands the grant to whoever
  // did not win last time. Fixed priority always favours requester 0.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      if (ROUND_ROBIN != 0) begin
        grant_id = ~last_grant;
      end else begin
        grant_id = 1'b0;
      end
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Reset is gated into accept so that a request presented together with
  // reset is never acknowledged.
  assign accept = (state == IDLE) && !rst && grant_any;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. EXEC always lasts exactly one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode. Only the winner sees ready, and only while IDLE.
  always_comb begin
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    busy       = (state != IDLE);
  end

  // Datapath registers. Operands are written only on accept, so they stay
  // frozen through EXEC and keep their last values afterwards. last_grant
  // moves only on accept. It starts at 1 so that requester 0 wins the first
  // contention after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant_id ? req1_a    : req0_a;
            op_b       <= grant_id ? req1_b    : req0_b;
            op_ctrl    <= grant_id ? req1_ctrl : req0_ctrl;
            op_id      <= grant_id;
            last_grant <= grant_id;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;

endmodule
